// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (I) and memory-stage (D) ports.
// Data wins ties; a starvation counter forces an I grant after STARVE_MAX back-to-back D grants.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST    = WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                grant_i;
    logic                grant_d;
    logic                finish;
    logic                abort;

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

    // Grants are withheld while any ready pulse is showing, so every transaction is followed by an IDLE gap.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!if_ready && !d_ready) begin
                    if (d_req && !(if_req && starve_cnt == STARVE_LIMIT)) begin
                        grant_d    = 1'b1;
                        next_state = BUSY_D;
                    end else if (if_req) begin
                        grant_i    = 1'b1;
                        next_state = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                wait_cnt  <= '0;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                wait_cnt   <= '0;
                starve_cnt <= '0;
            end else if (finish || abort) begin
                mem_req <= 1'b0;
                err     <= abort;
                if (state == BUSY_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= abort ? ERR_DATA : mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    // A completed write leaves the last read word in place.
                    if (abort) begin
                        d_rdata <= ERR_DATA;
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder model plus per-port scoreboards
// that are filled when requests are raised and drained on each ready pulse.
module tb_mem_port_arbiter;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    mem_port_arbiter #(
        .TIMEOUT    (16),
        .STARVE_MAX (4),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        hold;
    } exp_t;

    exp_t        i_q[$];
    exp_t        d_q[$];
    exp_t        mon_e;
    logic [31:0] model [0:255];
    logic [31:0] d_rdata_exp;
    int          compared   = 0;
    int          mismatched = 0;
    int          ack_delay;
    bit          ack_enable;
    bit          stray_ack;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input bit is_d, input bit we, input logic [31:0] addr, input bit timeout);
        exp_t e;
        e.hold  = is_d && we && !timeout;
        e.err   = timeout;
        e.rdata = timeout ? ERR_DATA : model[addr[9:2]];
        if (is_d) d_q.push_back(e);
        else      i_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit timeout);
        pushExpect(is_d, we, addr, timeout);
        if (is_d) begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
    endtask

    task automatic waitReady(input bit is_d, input int budget, input string tag);
        int n = 0;
        while (!(is_d ? d_ready : if_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(is_d ? d_ready : if_ready)) checkOutput({tag, " timed out"}, is_d ? d_ready : if_ready, 1);
    endtask

    // Memory model: acks the ack_delay-th BUSY cycle, performing the access at that moment.
    initial begin
        int busy = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !mem_req) begin
                busy    = 0;
                mem_ack = stray_ack;
            end else begin
                busy++;
                if (ack_enable && busy == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) model[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = model[mem_addr[9:2]];
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
    end

    // Scoreboard drain on every ready pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_ready) begin
                if (i_q.size() == 0) begin
                    checkOutput("unexpected if_ready", {31'b0, if_ready}, 0);
                end else begin
                    mon_e = i_q.pop_front();
                    checkOutput("sb if_rdata", if_rdata, mon_e.rdata);
                    checkOutput("sb if err", {31'b0, err}, {31'b0, mon_e.err});
                end
            end
            if (d_ready) begin
                if (d_q.size() == 0) begin
                    checkOutput("unexpected d_ready", {31'b0, d_ready}, 0);
                end else begin
                    mon_e = d_q.pop_front();
                    checkOutput("sb d err", {31'b0, err}, {31'b0, mon_e.err});
                    if (mon_e.hold) begin
                        checkOutput("sb d_rdata held", d_rdata, d_rdata_exp);
                    end else begin
                        checkOutput("sb d_rdata", d_rdata, mon_e.rdata);
                        d_rdata_exp = mon_e.rdata;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int order[$];
        int exp_order[6];
        int n;
        int busy_seen;

        reset       = 1'b1;
        if_req      = 1'b0;
        if_addr     = 32'h0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = 32'h0;
        d_wdata     = 32'h0;
        ack_enable  = 1'b1;
        ack_delay   = 1;
        stray_ack   = 1'b0;
        d_rdata_exp = 32'h0;
        for (int i = 0; i < 256; i++) model[i] = 32'h1000_0000 + i;

        repeat (2) @(negedge clk);
        checkOutput("reset mem_req", {31'b0, mem_req}, 0);
        checkOutput("reset if_ready", {31'b0, if_ready}, 0);
        checkOutput("reset d_ready", {31'b0, d_ready}, 0);
        checkOutput("reset err", {31'b0, err}, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset d_rdata", d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single I read, ack on the third BUSY cycle
        ack_delay = 3;
        model[64] = 32'h8C010004;
        applyStimulus(0, 0, 32'h100, 0, 0);
        #1 checkOutput("t1 if_stall c0", {31'b0, if_stall}, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1 mem_req c%0d", c), {31'b0, mem_req}, 1);
            checkOutput($sformatf("t1 if_stall c%0d", c), {31'b0, if_stall}, 1);
        end
        checkOutput("t1 mem_addr", mem_addr, 32'h100);
        checkOutput("t1 mem_we", {31'b0, mem_we}, 0);
        @(negedge clk);
        checkOutput("t1 if_ready c4", {31'b0, if_ready}, 1);
        checkOutput("t1 if_stall c4", {31'b0, if_stall}, 0);
        checkOutput("t1 mem_req c4", {31'b0, mem_req}, 0);
        if_req = 1'b0;

        // D write with immediate ack
        ack_delay = 1;
        @(negedge clk);
        applyStimulus(1, 1, 32'h54, 32'h7, 0);
        @(negedge clk);
        checkOutput("t2 mem_we", {31'b0, mem_we}, 1);
        checkOutput("t2 mem_wdata", mem_wdata, 32'h7);
        checkOutput("t2 mem_addr", mem_addr, 32'h54);
        @(negedge clk);
        checkOutput("t2 d_ready c2", {31'b0, d_ready}, 1);
        checkOutput("t2 err", {31'b0, err}, 0);
        d_req = 1'b0;
        d_we  = 1'b0;

        // Simultaneous requests: D first, I after the IDLE gap
        @(negedge clk);
        applyStimulus(1, 0, 32'h54, 0, 0);
        applyStimulus(0, 0, 32'h100, 0, 0);
        @(negedge clk);
        checkOutput("t3 first grant addr", mem_addr, 32'h54);
        @(negedge clk);
        checkOutput("t3 d_ready c2", {31'b0, d_ready}, 1);
        d_req = 1'b0;
        @(negedge clk);
        checkOutput("t3 mem_req c3", {31'b0, mem_req}, 0);
        checkOutput("t3 if_ready c3", {31'b0, if_ready}, 0);
        @(negedge clk);
        checkOutput("t3 mem_req c4", {31'b0, mem_req}, 1);
        checkOutput("t3 second grant addr", mem_addr, 32'h100);
        @(negedge clk);
        checkOutput("t3 if_ready c5", {31'b0, if_ready}, 1);
        if_req = 1'b0;

        // Starvation: both held, expect D D D D I D
        @(negedge clk);
        applyStimulus(1, 0, 32'h54, 0, 0);
        for (int k = 0; k < 4; k++) pushExpect(1, 0, 32'h54, 0);
        applyStimulus(0, 0, 32'h100, 0, 0);
        exp_order = '{0, 0, 0, 0, 1, 0};
        n = 0;
        while (order.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                order.push_back(0);
                if (order.size() == 6) d_req = 1'b0;
            end
            if (if_ready) begin
                order.push_back(1);
                if_req = 1'b0;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        checkOutput("t4 completions", order.size(), 6);
        for (int k = 0; k < order.size() && k < 6; k++) begin
            checkOutput($sformatf("t4 order[%0d]", k), order[k], exp_order[k]);
        end

        // Timeout abort on a D read
        ack_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1, 0, 32'h20, 0, 1);
        busy_seen = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (mem_req) busy_seen++;
        end
        checkOutput("t5 busy cycles", busy_seen, 16);
        @(negedge clk);
        checkOutput("t5 d_ready c17", {31'b0, d_ready}, 1);
        checkOutput("t5 err c17", {31'b0, err}, 1);
        checkOutput("t5 mem_req c17", {31'b0, mem_req}, 0);
        checkOutput("t5 d_rdata", d_rdata, ERR_DATA);
        d_req      = 1'b0;
        ack_enable = 1'b1;
        @(negedge clk);
        checkOutput("t5 err pulse width", {31'b0, err}, 0);

        // Ack coinciding with the timeout limit wins
        ack_delay = 16;
        @(negedge clk);
        applyStimulus(1, 0, 32'h54, 0, 0);
        repeat (16) @(negedge clk);
        @(negedge clk);
        checkOutput("t5b d_ready c17", {31'b0, d_ready}, 1);
        checkOutput("t5b err", {31'b0, err}, 0);
        d_req = 1'b0;

        // Reset in the middle of a BUSY_I transaction, then a stray ack, then a clean read
        ack_enable = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6 mem_req before reset", {31'b0, mem_req}, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6 mem_req async drop", {31'b0, mem_req}, 0);
        checkOutput("t6 if_rdata reset", if_rdata, 0);
        checkOutput("t6 mem_addr reset", mem_addr, 0);
        if_req = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t6 stray mem_req %0d", c), {31'b0, mem_req}, 0);
            checkOutput($sformatf("t6 stray if_ready %0d", c), {31'b0, if_ready}, 0);
            checkOutput($sformatf("t6 stray err %0d", c), {31'b0, err}, 0);
        end
        ack_enable = 1'b1;
        ack_delay  = 2;
        applyStimulus(0, 0, 32'h100, 0, 0);
        waitReady(0, 20, "t6 post-reset read");
        if_req = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("sb i_q drained", i_q.size(), 0);
        checkOutput("sb d_q drained", d_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
